// File: rtl/palette_sprite_loader.sv
// Sprite palette loader: CPU writes land in a shadow palette and are committed to the live palette on request.
// Optional shadow readback port is enabled by defining PALETTE_SPRITE_READBACK_EN.
module palette_sprite_loader #(
    parameter int RGB_BIT = 12
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [3:0]         wr_addr,
    input  logic [RGB_BIT-1:0] wr_data,
    input  logic               commit_req,
    output logic               commit_busy,
    output logic               commit_done,
    input  logic [1:0]         PaletteChoice,
    output logic [RGB_BIT-1:0] PaletteColor00,
    output logic [RGB_BIT-1:0] PaletteColor01,
    output logic [RGB_BIT-1:0] PaletteColor10,
    output logic [RGB_BIT-1:0] PaletteColor11
`ifdef PALETTE_SPRITE_READBACK_EN
    ,
    input  logic               rd_en,
    input  logic [3:0]         rd_addr,
    output logic [RGB_BIT-1:0] rd_data
`endif
);

    typedef enum logic {
        S_IDLE,
        S_COPY
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cnt;
    logic               r_done;
    logic [3:0]         r_dirty;
    logic [RGB_BIT-1:0] r_shadow [4][4];
    logic [RGB_BIT-1:0] r_live   [4][4];

    logic [1:0]         w_wr_pal;
    logic [1:0]         w_wr_slot;

    assign w_wr_pal    = wr_addr[3:2];
    assign w_wr_slot   = wr_addr[1:0];
    assign wr_ready    = (r_state == S_IDLE);
    assign commit_busy = (r_state == S_COPY);
    assign commit_done = r_done;

    // Writes are only accepted in IDLE, so they never race the dirty-clear done during COPY.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_dirty  <= '0;
            r_shadow <= '{default: '{default: '0}};
            r_live   <= '{default: '{default: '0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_valid) begin
                        r_shadow[w_wr_pal][w_wr_slot] <= wr_data;
                        r_dirty[w_wr_pal]             <= 1'b1;
                    end
                    if (commit_req) begin
                        r_state <= S_COPY;
                        r_cnt   <= '0;
                    end
                end
                S_COPY: begin
                    if (r_dirty[r_cnt]) begin
                        r_live[r_cnt]  <= r_shadow[r_cnt];
                        r_dirty[r_cnt] <= 1'b0;
                    end
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign PaletteColor00 = r_live[PaletteChoice][0];
    assign PaletteColor01 = r_live[PaletteChoice][1];
    assign PaletteColor10 = r_live[PaletteChoice][2];
    assign PaletteColor11 = r_live[PaletteChoice][3];

`ifdef PALETTE_SPRITE_READBACK_EN
    // Reads sample the pre-edge shadow, so a same-edge write returns the old value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= r_shadow[rd_addr[3:2]][rd_addr[1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_palette_sprite_loader.sv
// Self-checking bench for palette_sprite_loader: directed vector table, hand sequences and a random run
// against an edge-numbered reference model. Readback checks are built when PALETTE_SPRITE_READBACK_EN is defined.
module tb_palette_sprite_loader;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rstn;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         commit_req;
    logic         commit_busy;
    logic         commit_done;
    logic [1:0]   PaletteChoice;
    logic [W-1:0] PaletteColor00, PaletteColor01, PaletteColor10, PaletteColor11;
`ifdef PALETTE_SPRITE_READBACK_EN
    logic         rd_en;
    logic [3:0]   rd_addr;
    logic [W-1:0] rd_data;
`endif

    palette_sprite_loader #(.RGB_BIT(W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .commit_busy    (commit_busy),
        .commit_done    (commit_done),
        .PaletteChoice  (PaletteChoice),
        .PaletteColor00 (PaletteColor00),
        .PaletteColor01 (PaletteColor01),
        .PaletteColor10 (PaletteColor10),
        .PaletteColor11 (PaletteColor11)
`ifdef PALETTE_SPRITE_READBACK_EN
        ,
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] dut_col [4];
    assign dut_col[0] = PaletteColor00;
    assign dut_col[1] = PaletteColor01;
    assign dut_col[2] = PaletteColor10;
    assign dut_col[3] = PaletteColor11;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a commit started at edge S copies palette p at edge S+1+p and finishes at S+4.
    logic [W-1:0] m_shadow [4][4];
    logic [W-1:0] m_live   [4][4];
    bit           m_dirty  [4];
    int           m_start;
    int           m_edge;
    bit           m_done;
    logic [W-1:0] m_rd;

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            m_dirty[p] = 1'b0;
            for (int s = 0; s < 4; s++) begin
                m_shadow[p][s] = '0;
                m_live[p][s]   = '0;
            end
        end
        m_start = -1;
        m_done  = 1'b0;
        m_rd    = '0;
    endtask

    task automatic model_edge();
        bit busy;
        int p;
        m_edge++;
        busy   = (m_start >= 0) && (m_edge > m_start) && (m_edge <= m_start + 4);
        m_done = 1'b0;
`ifdef PALETTE_SPRITE_READBACK_EN
        if (rd_en) m_rd = m_shadow[rd_addr[3:2]][rd_addr[1:0]];
`endif
        if (busy) begin
            p = m_edge - m_start - 1;
            if (m_dirty[p]) begin
                for (int s = 0; s < 4; s++) m_live[p][s] = m_shadow[p][s];
                m_dirty[p] = 1'b0;
            end
            if (p == 3) begin
                m_done  = 1'b1;
                m_start = -1;
            end
        end else begin
            if (wr_valid) begin
                m_shadow[wr_addr[3:2]][wr_addr[1:0]] = wr_data;
                m_dirty[wr_addr[3:2]] = 1'b1;
            end
            if (commit_req) m_start = m_edge;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ready"}, {31'b0, wr_ready},    {31'b0, (m_start < 0)});
        chk({tag, "_busy"},  {31'b0, commit_busy}, {31'b0, (m_start >= 0)});
        chk({tag, "_done"},  {31'b0, commit_done}, {31'b0, m_done});
        for (int s = 0; s < 4; s++)
            chk($sformatf("%s_col%0d", tag, s), {20'b0, dut_col[s]}, {20'b0, m_live[PaletteChoice][s]});
`ifdef PALETTE_SPRITE_READBACK_EN
        chk({tag, "_rd"}, {20'b0, rd_data}, {20'b0, m_rd});
`endif
    endtask

    task automatic chk_pal(input string tag, input logic [1:0] p,
                           input logic [W-1:0] c0, input logic [W-1:0] c1,
                           input logic [W-1:0] c2, input logic [W-1:0] c3);
        logic [1:0] saved;
        saved = PaletteChoice;
        PaletteChoice = p;
        #1;
        chk($sformatf("%s_p%0d_c0", tag, p), {20'b0, PaletteColor00}, {20'b0, c0});
        chk($sformatf("%s_p%0d_c1", tag, p), {20'b0, PaletteColor01}, {20'b0, c1});
        chk($sformatf("%s_p%0d_c2", tag, p), {20'b0, PaletteColor10}, {20'b0, c2});
        chk($sformatf("%s_p%0d_c3", tag, p), {20'b0, PaletteColor11}, {20'b0, c3});
        PaletteChoice = saved;
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, {31'b0, wr_ready},    32'd1);
        chk({tag, "_busy"},  {31'b0, commit_busy}, 32'd0);
        for (int p = 0; p < 4; p++) chk_pal(tag, 2'(p), '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        wr_valid = 1'b0;
        commit_req = 1'b0;
`ifdef PALETTE_SPRITE_READBACK_EN
        rd_en = 1'b0;
`endif
        #1;
        model_clear();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic do_commit(input string tag);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check_model(tag);
        repeat (5) begin
            tick();
            check_model(tag);
        end
    endtask

    typedef struct {
        logic         wv;
        logic [3:0]   wa;
        logic [W-1:0] wd;
        logic         cr;
        logic [1:0]   ch;
        logic         e_ready;
        logic         e_busy;
        logic         e_done;
        logic [W-1:0] e_col [4];
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [3:0] wa, input logic [W-1:0] wd,
                                input logic cr, input logic [1:0] ch,
                                input logic er, input logic eb, input logic ed,
                                input logic [W-1:0] c0, input logic [W-1:0] c1,
                                input logic [W-1:0] c2, input logic [W-1:0] c3);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.cr = cr; v.ch = ch;
        v.e_ready = er; v.e_busy = eb; v.e_done = ed;
        v.e_col[0] = c0; v.e_col[1] = c1; v.e_col[2] = c2; v.e_col[3] = c3;
        return v;
    endfunction

    vec_t vt [15];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ch_keep;
        int busy_cnt;
        int done_cnt;

        m_edge        = 0;
        rstn          = 1'b0;
        wr_valid      = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        commit_req    = 1'b0;
        PaletteChoice = '0;
`ifdef PALETTE_SPRITE_READBACK_EN
        rd_en   = 1'b0;
        rd_addr = '0;
`endif
        model_clear();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk_idle_zero("reset");
        chk("reset_done", {31'b0, commit_done}, 32'd0);

        // Write-before-commit, then write on the commit edge and a commit_req ignored during COPY.
        vt[0]  = mk(1, 4'b0110, 12'hF80, 0, 1,  1, 0, 0,  '0, '0, '0, '0);
        vt[1]  = mk(0, 4'h0,    12'h000, 0, 1,  1, 0, 0,  '0, '0, '0, '0);
        vt[2]  = mk(0, 4'h0,    12'h000, 1, 1,  0, 1, 0,  '0, '0, '0, '0);
        vt[3]  = mk(0, 4'h0,    12'h000, 0, 1,  0, 1, 0,  '0, '0, '0, '0);
        vt[4]  = mk(0, 4'h0,    12'h000, 0, 1,  0, 1, 0,  '0, '0, 12'hF80, '0);
        vt[5]  = mk(0, 4'h0,    12'h000, 0, 1,  0, 1, 0,  '0, '0, 12'hF80, '0);
        vt[6]  = mk(0, 4'h0,    12'h000, 0, 1,  1, 0, 1,  '0, '0, 12'hF80, '0);
        vt[7]  = mk(0, 4'h0,    12'h000, 0, 1,  1, 0, 0,  '0, '0, 12'hF80, '0);
        vt[8]  = mk(1, 4'b0000, 12'h123, 1, 0,  0, 1, 0,  '0, '0, '0, '0);
        vt[9]  = mk(0, 4'h0,    12'h000, 0, 0,  0, 1, 0,  12'h123, '0, '0, '0);
        vt[10] = mk(0, 4'h0,    12'h000, 1, 0,  0, 1, 0,  12'h123, '0, '0, '0);
        vt[11] = mk(0, 4'h0,    12'h000, 0, 0,  0, 1, 0,  12'h123, '0, '0, '0);
        vt[12] = mk(0, 4'h0,    12'h000, 0, 0,  1, 0, 1,  12'h123, '0, '0, '0);
        vt[13] = mk(0, 4'h0,    12'h000, 0, 0,  1, 0, 0,  12'h123, '0, '0, '0);
        vt[14] = mk(0, 4'h0,    12'h000, 0, 1,  1, 0, 0,  '0, '0, 12'hF80, '0);

        for (int i = 0; i < 15; i++) begin
            wr_valid      = vt[i].wv;
            wr_addr       = vt[i].wa;
            wr_data       = vt[i].wd;
            commit_req    = vt[i].cr;
            PaletteChoice = vt[i].ch;
            tick();
            chk($sformatf("vec%0d_ready", i), {31'b0, wr_ready},    {31'b0, vt[i].e_ready});
            chk($sformatf("vec%0d_busy", i),  {31'b0, commit_busy}, {31'b0, vt[i].e_busy});
            chk($sformatf("vec%0d_done", i),  {31'b0, commit_done}, {31'b0, vt[i].e_done});
            for (int s = 0; s < 4; s++)
                chk($sformatf("vec%0d_col%0d", i, s), {20'b0, dut_col[s]}, {20'b0, vt[i].e_col[s]});
        end
        wr_valid   = 1'b0;
        commit_req = 1'b0;

`ifdef PALETTE_SPRITE_READBACK_EN
        rd_en   = 1'b1;
        rd_addr = 4'b0110;
        tick();
        chk("rdback_f80", {20'b0, rd_data}, {20'b0, 12'hF80});
        wr_valid = 1'b1;
        wr_addr  = 4'b0110;
        wr_data  = 12'hABC;
        tick();
        wr_valid = 1'b0;
        chk("rdback_same_edge_old", {20'b0, rd_data}, {20'b0, 12'hF80});
        tick();
        chk("rdback_new", {20'b0, rd_data}, {20'b0, 12'hABC});
        rd_en = 1'b0;
        tick();
        chk("rdback_hold", {20'b0, rd_data}, {20'b0, 12'hABC});
`endif

        // Mid-run reset clears everything.
        do_reset();
        chk_idle_zero("reset2");

        // Stall: write held through a COPY lands at N+5 and needs a second commit.
        commit_req = 1'b1;
        tick();
        commit_req    = 1'b0;
        wr_valid      = 1'b1;
        wr_addr       = 4'hF;
        wr_data       = 12'h0AB;
        PaletteChoice = 2'd3;
        chk("stall_ready_n0", {31'b0, wr_ready}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("stall_ready_n%0d", k), {31'b0, wr_ready}, (k == 4) ? 32'd1 : 32'd0);
            check_model($sformatf("stall%0d", k));
        end
        tick();
        wr_valid = 1'b0;
        chk("stall_not_live", {20'b0, PaletteColor11}, 32'd0);
        do_commit("stall_commit");
        chk("stall_live", {20'b0, PaletteColor11}, {20'b0, 12'h0AB});

        // Dirty filtering: populate palettes 1 and 3, then commit only palettes 0 and 2.
        wr_valid = 1'b1;
        wr_addr = 4'h4; wr_data = 12'h111; tick();
        wr_addr = 4'hD; wr_data = 12'h333; tick();
        wr_valid = 1'b0;
        do_commit("fill_commit");
        wr_valid = 1'b1;
        wr_addr = 4'h1; wr_data = 12'h555; tick();
        wr_addr = 4'h1; wr_data = 12'hAAA; tick();
        wr_addr = 4'h8; wr_data = 12'hBBB; tick();
        wr_valid = 1'b0;
        chk_pal("pre_commit", 2'd0, '0, '0, '0, '0);
        do_commit("dirty_commit");
        chk_pal("dirty", 2'd0, '0, 12'hAAA, '0, '0);
        chk_pal("dirty", 2'd1, 12'h111, '0, '0, '0);
        chk_pal("dirty", 2'd2, 12'hBBB, '0, '0, '0);
        chk_pal("dirty", 2'd3, '0, 12'h333, '0, 12'h0AB);

        // Commit with nothing dirty still runs the full COPY.
        commit_req = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            commit_req = 1'b0;
            if (commit_busy) busy_cnt++;
            if (commit_done) done_cnt++;
        end
        chk("empty_busy_cycles", busy_cnt, 32'd4);
        chk("empty_done_pulses", done_cnt, 32'd1);
        chk_pal("empty", 2'd0, '0, 12'hAAA, '0, '0);
        chk_pal("empty", 2'd3, '0, 12'h333, '0, 12'h0AB);

        // Reset asserted mid-COPY: immediate IDLE, no done pulse, everything cleared.
        wr_valid = 1'b1; wr_addr = 4'h2; wr_data = 12'h777; tick();
        wr_valid = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        chk("midcopy_async_busy",  {31'b0, commit_busy}, 32'd0);
        chk("midcopy_async_ready", {31'b0, wr_ready},    32'd1);
        model_clear();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (commit_done) done_cnt++;
        end
        chk("midcopy_no_done", done_cnt, 32'd0);
        chk_idle_zero("midcopy");

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            wr_valid      = 1'($urandom_range(0, 1));
            wr_addr       = 4'($urandom_range(0, 15));
            wr_data       = 12'($urandom_range(0, 4095));
            commit_req    = ($urandom_range(0, 7) == 0);
            PaletteChoice = 2'($urandom_range(0, 3));
`ifdef PALETTE_SPRITE_READBACK_EN
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = 4'($urandom_range(0, 15));
`endif
            tick();
            check_model($sformatf("rnd%0d", i));
            if (i == 300) begin
                do_reset();
                check_model("rnd_reset");
            end
        end
        wr_valid   = 1'b0;
        commit_req = 1'b0;
        ch_keep = PaletteChoice;
        for (int p = 0; p < 4; p++)
            chk_pal("rnd_final", 2'(p), m_live[p][0], m_live[p][1], m_live[p][2], m_live[p][3]);
        PaletteChoice = ch_keep;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
